timer_ctrl_4b: RTL and testbench
================================

# timer_ctrl_4b

Sequencing controller for the 4-bit up-counter datapath (`up_counter_4b`) that turns it into a one-shot programmable delay timer. Accepts a start request with a 4-bit period P and drives the counter's `ld`/`cnt` controls. Signals completion with a one-cycle `done` pulse exactly P+2 cycles after start is accepted. Sits between the top-level control FSMs and the counter; any block needing a short timed wait instantiates it.

## Interface
Parameters: none (width fixed at 4 bits).
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset; one clock, synchronous and active-high
- `start`  in  1  request a timing run; sampled only in IDLE
- `period`  in  4  delay P, sampled together with an accepted `start`
- `stop`  in  1  abort the current run; sampled in LOAD/RUN
- `periodic`  in  1  auto-reload request, sampled with `start`; present only with `TIMER_CTRL_RELOAD_EN`
- `busy`  out  1  high whenever state != IDLE
- `done`  out  1  one-cycle completion pulse (high in DONE state)
- `count`  out  4  current counter value (pass-through from the counter)

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: `start`=1 → latch `period` into `period_q` (and `periodic` into `per_q` when enabled), go to LOAD. `stop` is ignored in IDLE.
- LOAD: assert counter `ld`=1 with load data = ~`period_q` (that is, 15−P), then go to RUN. `stop`=1 → IDLE with no load performed.
- RUN: while counter `tcount`=0, assert `cnt`=1. When `tcount`=1 (count==4'hF), deassert `cnt` (count holds at F) and go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` asserted outside IDLE is ignored and not queued. Changes to `period` after acceptance have no effect on the run.
- Simultaneous `stop` and `tcount` in RUN: `stop` wins → IDLE, no `done`.
- P=0: the counter loads F, so `tcount` is seen on the first RUN cycle. P=15: the counter loads 0 and counts 0→F.
- The counter never wraps: `cnt` is deasserted at F, so the counter's wrap-around is never exercised.
- Aborted runs leave `count` at its last value. The next LOAD overwrites it.

## Timing
- Reset: state=IDLE, `busy`=0, `done`=0, `count`=0, `period_q`=0, `per_q`=0. `rst` also resets the counter.
- Reset mid-run: returns to IDLE on that edge; no `done` pulse is emitted.
- `start` accepted at edge k:
  - LOAD is active for cycle k..k+1.
  - `count`=15−P after edge k+1.
  - `count`=15 after edge k+1+P.
  - `done` is high between edges k+P+2 and k+P+3.
- Start-to-done latency is P+2 cycles. `busy` is high for P+3 cycles starting after edge k.
- Back-to-back one-shot runs: the earliest next `start` is accepted at the edge where DONE→IDLE has already occurred, i.e. the edge after `done` falls.
- `done` and `busy` are decoded from state registers; they are glitch-free with no combinational input-to-output path.

## Configuration
- `TIMER_CTRL_RELOAD_EN` defined:
  - The `periodic` port and `per_q` exist.
  - DONE with `per_q`=1 goes to LOAD instead of IDLE, reusing `period_q`.
  - `done` then pulses every P+3 cycles until `stop` (honoured in LOAD/RUN) or `rst`.
  - `busy` stays high between pulses.
- Not defined: the `periodic` port is absent and DONE always returns to IDLE (one-shot only).

## Structure
- Shared include `Timer_Ctrl_Defs.vh`: state encodings `IDLE`=2'b00, `LOAD`=2'b01, `RUN`=2'b10, `DONE`=2'b11.
- One sub-module: an instance of `up_counter_4b`.
  - `in` = ~`period_q`; `ld` from LOAD; `cnt` from RUN && !`tcount`.
  - `clk`, `rst` are shared.
  - `count` drives the output; `tcount` feeds the FSM.
- FSM next-state and output decode are implemented in this block.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles → `busy`=0, `done`=0, `count`=0; `stop`=1 in IDLE causes no change.
- One-shot P=5: `start` at edge 10 → `count`=10 after edge 11, `count`=15 after edge 16, `done` high for the single cycle after edge 17, `busy` falls after edge 18.
- Boundaries: P=0 → `done` 2 cycles after accept. P=15 → counter sequence 0…F, `done` 17 cycles after accept. No wrap to 0 in either case.
- Abort: P=8, `stop`=1 three cycles into RUN → IDLE next edge, no `done`; a `start` during RUN is ignored and not queued.
- Reset mid-run: P=10, `rst` pulsed during RUN → IDLE, `count`=0, no `done`; a fresh run with P=3 then completes in 5 cycles.
- With `TIMER_CTRL_RELOAD_EN`, P=2, `periodic`=1: `done` pulses every 5 cycles for 4 periods; `stop` during the 5th RUN ends the run with no further pulses.

Source files
------------

// File: rtl/timer_ctrl_4b_pkg.sv
// Shared types for the one-shot / auto-reload delay timer controller.
// State encodings match the datapath-control convention IDLE=00, LOAD=01, RUN=10, DONE=11.
package timer_ctrl_4b_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    // Loading the complement lets the counter reach F after exactly P increments.
    function automatic logic [CNT_W-1:0] load_value(input logic [CNT_W-1:0] p);
        return ~p;
    endfunction

endpackage

// File: rtl/up_counter_4b.sv
// 4-bit loadable up-counter datapath; tcount flags the terminal value F.
// Load has priority over count enable.
module up_counter_4b (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic       cnt,
    input  logic [3:0] in,
    output logic [3:0] count,
    output logic       tcount
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 4'h0;
        end else if (ld) begin
            count <= in;
        end else if (cnt) begin
            count <= count + 4'h1;
        end
    end

    assign tcount = (count == 4'hF);

endmodule

// File: rtl/timer_ctrl_4b.sv
// Programmable delay timer: sequences up_counter_4b so done pulses P+2 cycles after start.
// Optional auto-reload mode is enabled by defining TIMER_CTRL_RELOAD_EN.
module timer_ctrl_4b
    import timer_ctrl_4b_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  period,
    input  logic        stop,
`ifdef TIMER_CTRL_RELOAD_EN
    input  logic        periodic,
`endif
    output logic        busy,
    output logic        done,
    output logic [3:0]  count,
    output state_t      state_dbg
);

    // Handshake: start is a level request with no ready; it is taken only in IDLE
    // (busy=0) together with period, and is dropped, not queued, while busy=1.
    state_t     state_q;
    state_t     state_d;
    logic [3:0] period_q;
    logic       ld;
    logic       cnt;
    logic       tcount;
    logic       reload;

`ifdef TIMER_CTRL_RELOAD_EN
    logic per_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            per_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            per_q <= periodic;
        end
    end

    assign reload = per_q;
`else
    assign reload = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            period_q <= 4'h0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                period_q <= period;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        cnt     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    ld      = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Holding at F means the counter never wraps; stop beats tcount.
                cnt = !tcount;
                if (stop)        state_d = IDLE;
                else if (tcount) state_d = DONE;
            end
            DONE: begin
                state_d = reload ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    up_counter_4b u_counter (
        .clk    (clk),
        .rst    (rst),
        .ld     (ld),
        .cnt    (cnt),
        .in     (load_value(period_q)),
        .count  (count),
        .tcount (tcount)
    );

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_timer_ctrl_4b.sv
// Self-checking bench for timer_ctrl_4b: directed scenarios plus random traffic
// checked every cycle against a phase-based reference model of the timer's timing rules.
module tb_timer_ctrl_4b;
    import timer_ctrl_4b_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] period = 4'h0;
    logic       stop = 1'b0;
    logic       periodic = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] count;
    state_t     state_dbg;

    int n_pass = 0;
    int n_total = 0;
    logic [3:0] exp_q[$];

    // Reference model: run phase t counts cycles since acceptance (0 = load cycle,
    // 1..P+1 = counting, P+2 = done cycle).
    bit m_active = 1'b0;
    int m_t = 0;
    int m_p = 0;
    int m_count = 0;
    bit m_per = 1'b0;

    timer_ctrl_4b dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .period    (period),
        .stop      (stop),
`ifdef TIMER_CTRL_RELOAD_EN
        .periodic  (periodic),
`endif
        .busy      (busy),
        .done      (done),
        .count     (count),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_step();
        if (rst) begin
            m_active = 1'b0;
            m_count  = 0;
            m_per    = 1'b0;
            m_p      = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_t      = 0;
                m_p      = int'(period);
`ifdef TIMER_CTRL_RELOAD_EN
                m_per    = periodic;
`else
                m_per    = 1'b0;
`endif
            end
        end else if (m_t == 0) begin
            if (stop) m_active = 1'b0;
            else begin
                m_count = 15 - m_p;
                m_t     = 1;
            end
        end else if (m_t <= m_p + 1) begin
            if (m_count < 15) m_count++;
            if (stop) m_active = 1'b0;
            else m_t++;
        end else begin
            if (m_per) m_t = 0;
            else m_active = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("busy", int'(busy), int'(m_active));
        check("done", int'(done), int'(m_active && m_t == m_p + 2));
        check("count", int'(count), m_count);
    endtask

    task automatic accept(input logic [3:0] p);
        start  = 1'b1;
        period = p;
        tick();
        start  = 1'b0;
        period = 4'($urandom_range(0, 15));
    endtask

    // Starts a run and measures cycles from the accepting edge to the first done.
    task automatic timed_run(input logic [3:0] p, input string tag);
        int n;
        accept(p);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check(tag, n, int'(p) + 2);
        tick();
        check({tag, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int n;
        int seen;

        // Reset and idle behaviour.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_count", int'(count), 0);
        stop = 1'b1;
        repeat (3) tick();
        stop = 1'b0;
        check("idle_stop_busy", int'(busy), 0);

        // One-shot P=5 with count milestones.
        accept(4'd5);
        tick();
        check("p5_load", int'(count), 10);
        repeat (5) tick();
        check("p5_full", int'(count), 15);
        tick();
        check("p5_done", int'(done), 1);
        tick();
        check("p5_busy_fall", int'(busy), 0);

        // Boundaries.
        timed_run(4'd0, "lat_p0");
        check("p0_nowrap", int'(count), 15);
        accept(4'd15);
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        for (int i = 0; i < 16; i++) begin
            tick();
            check("p15_seq", int'(count), int'(exp_q.pop_front()));
        end
        n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        check("p15_done_after_F", n, 1);
        tick();
        check("p15_nowrap", int'(count), 15);
        timed_run(4'd7, "lat_p7");

        // Abort with an ignored start during RUN.
        accept(4'd8);
        tick();
        start  = 1'b1;
        period = 4'd1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("abort_idle", int'(busy), 0);
        seen = 0;
        repeat (20) begin
            tick();
            if (done || busy) seen++;
        end
        check("abort_no_done_no_queue", seen, 0);

        // Reset in the middle of a run, then a fresh run.
        accept(4'd10);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_count", int'(count), 0);
        timed_run(4'd3, "lat_p3_after_rst");

`ifdef TIMER_CTRL_RELOAD_EN
        // Auto-reload: pulses every P+3 cycles until stop.
        periodic = 1'b1;
        accept(4'd2);
        periodic = 1'b0;
        seen = 0;
        for (int i = 1; i <= 21; i++) begin
            tick();
            if (done) begin
                check("reload_pulse_time", i, 4 + 5 * seen);
                seen++;
            end
        end
        check("reload_pulses", seen, 4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        seen = 0;
        repeat (12) begin
            tick();
            if (done) seen++;
        end
        check("reload_stopped", seen, 0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            period   = 4'($urandom_range(0, 15));
            stop     = ($urandom_range(0, 15) == 0);
            rst      = ($urandom_range(0, 63) == 0);
            periodic = ($urandom_range(0, 1) == 1);
            tick();
        end
        start = 1'b0;
        stop  = 1'b0;
        rst   = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
